scan_controller: RTL and testbench

SCAN_CONTROLLER -- requirements
Module: scan_controller

---
 rtl/solar_tracker_pkg.sv | 21 ++
 rtl/settle_timer.sv | 32 +++
 rtl/scan_controller.sv | 141 ++++++++++++++
 tb/tb_scan_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/solar_tracker_pkg.sv
// Shared constants and state encoding for the solar tracker scan logic.
package solar_tracker_pkg;

    localparam int unsigned PW_MIN     = 500;
    localparam int unsigned PW_MAX     = 2500;
    localparam int unsigned PW_STEP    = 100;
    localparam int unsigned SETTLE_CYC = 2000000;
    localparam int unsigned ADC_TMO    = 1000;

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StSettle,
        StSample,
        StWaitAdc,
        StNext,
        StPark,
        StParkSettle
    } scan_state_e;

endpackage

// File: rtl/settle_timer.sv
// Down-counter shared by settle and ADC-timeout waits; expire_o is high for the last counted cycle.
module settle_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    output logic        expire_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N gives exactly N cycles before expiry is seen.
    assign expire_o = (cnt_q == 32'd1);

endmodule

// File: rtl/scan_controller.sv
// Raster-scans the servo pair over the pulse-width grid, sampling the ADC at each point,
// then parks on the best position reported by the max-register stage.
module scan_controller #(
    parameter int unsigned PW_MIN     = solar_tracker_pkg::PW_MIN,
    parameter int unsigned PW_MAX     = solar_tracker_pkg::PW_MAX,
    parameter int unsigned PW_STEP    = solar_tracker_pkg::PW_STEP,
    parameter int unsigned SETTLE_CYC = solar_tracker_pkg::SETTLE_CYC,
    parameter int unsigned ADC_TMO    = solar_tracker_pkg::ADC_TMO
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        ADC_VALID,
    input  logic [31:0] pulseWidth_max_H,
    input  logic [31:0] pulseWidth_max_V,
    output logic [31:0] pulseWidth_H,
    output logic [31:0] pulseWidth_V,
    output logic        SAMPLE_REQ,
    output logic        CAPTURE_EN,
    output logic        BUSY,
    output logic        DONE,
    output logic        TIMEOUT
);

    import solar_tracker_pkg::*;

    scan_state_e state_q;
    logic [31:0] scan_h_q, scan_v_q;
    logic [31:0] pw_h_q, pw_v_q;
    logic        sample_req_q, capture_q, busy_q, done_q, timeout_q;

    logic        tmr_load, tmr_expire;
    logic [31:0] tmr_val;
    logic [32:0] h_sum, v_sum;

    // One extra bit so a step past 2^32-1 still compares as out of range.
    assign h_sum = {1'b0, scan_h_q} + 33'(PW_STEP);
    assign v_sum = {1'b0, scan_v_q} + 33'(PW_STEP);

    assign tmr_load = (state_q == StMove) || (state_q == StSample) || (state_q == StPark);
    assign tmr_val  = (state_q == StSample) ? ADC_TMO : SETTLE_CYC;

    settle_timer u_settle_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            scan_h_q     <= '0;
            scan_v_q     <= '0;
            pw_h_q       <= PW_MIN;
            pw_v_q       <= PW_MIN;
            sample_req_q <= 1'b0;
            capture_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            sample_req_q <= 1'b0;
            done_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        scan_h_q  <= PW_MIN;
                        scan_v_q  <= PW_MIN;
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                        state_q   <= StMove;
                    end
                end
                StMove: begin
                    pw_h_q  <= scan_h_q;
                    pw_v_q  <= scan_v_q;
                    state_q <= StSettle;
                end
                StSettle: begin
                    if (tmr_expire) begin
                        sample_req_q <= 1'b1;
                        state_q      <= StSample;
                    end
                end
                StSample: begin
                    capture_q <= 1'b1;
                    state_q   <= StWaitAdc;
                end
                StWaitAdc: begin
                    // A conversion arriving on the final timeout cycle still wins.
                    if (ADC_VALID) begin
                        capture_q <= 1'b0;
                        state_q   <= StNext;
                    end else if (tmr_expire) begin
                        capture_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= StNext;
                    end
                end
                StNext: begin
                    if (h_sum > 33'(PW_MAX)) begin
                        scan_h_q <= PW_MIN;
                        if (v_sum > 33'(PW_MAX)) begin
                            state_q <= StPark;
                        end else begin
                            scan_v_q <= v_sum[31:0];
                            state_q  <= StMove;
                        end
                    end else begin
                        scan_h_q <= h_sum[31:0];
                        state_q  <= StMove;
                    end
                end
                StPark: begin
                    pw_h_q  <= pulseWidth_max_H;
                    pw_v_q  <= pulseWidth_max_V;
                    state_q <= StParkSettle;
                end
                StParkSettle: begin
                    if (tmr_expire) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pulseWidth_H = pw_h_q;
    assign pulseWidth_V = pw_v_q;
    assign SAMPLE_REQ   = sample_req_q;
    assign CAPTURE_EN   = capture_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign TIMEOUT      = timeout_q;

endmodule

// File: tb/tb_scan_controller.sv
// Scoreboard bench for scan_controller on a 3x3 grid with short settle/timeout windows.
module tb_scan_controller;

    localparam int unsigned PMIN  = 500;
    localparam int unsigned PMAX  = 700;
    localparam int unsigned PSTEP = 100;
    localparam int unsigned SCYC  = 4;
    localparam int unsigned TMO   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        adc_resp = 1'b0;
    logic        stray_valid = 1'b0;
    logic        adc_valid;
    logic [31:0] max_h = 32'd600;
    logic [31:0] max_v = 32'd700;
    logic [31:0] pw_h, pw_v;
    logic        sample_req, capture_en, busy, done, timeout;

    assign adc_valid = adc_resp | stray_valid;

    always #5 clk = ~clk;

    scan_controller #(
        .PW_MIN     (PMIN),
        .PW_MAX     (PMAX),
        .PW_STEP    (PSTEP),
        .SETTLE_CYC (SCYC),
        .ADC_TMO    (TMO)
    ) dut (
        .CLK              (clk),
        .RST              (rst),
        .START            (start),
        .ADC_VALID        (adc_valid),
        .pulseWidth_max_H (max_h),
        .pulseWidth_max_V (max_v),
        .pulseWidth_H     (pw_h),
        .pulseWidth_V     (pw_v),
        .SAMPLE_REQ       (sample_req),
        .CAPTURE_EN       (capture_en),
        .BUSY             (busy),
        .DONE             (done),
        .TIMEOUT          (timeout)
    );

    typedef struct {
        int unsigned h;
        int unsigned v;
        int          win;
        bit          tmo;
    } pt_t;

    pt_t         exp_q[$];
    int unsigned done_h_q[$];
    int unsigned done_v_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_samples = 0;
    int          n_done = 0;

    // Hand-computed raster order, H inner.
    int unsigned exp_h[9] = '{500, 600, 700, 500, 600, 700, 500, 600, 700};
    int unsigned exp_v[9] = '{500, 500, 500, 600, 600, 600, 700, 700, 700};
    int          win_v[9];
    bit          tmo_v[9];
    int          resp_delay[9];
    int          resp_idx = 0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_scan(input int n, input bit with_done);
        for (int k = 0; k < n; k++) begin
            pt_t p;
            p.h   = exp_h[k];
            p.v   = exp_v[k];
            p.win = win_v[k];
            p.tmo = tmo_v[k];
            exp_q.push_back(p);
        end
        if (with_done) begin
            done_h_q.push_back(600);
            done_v_q.push_back(700);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", done, 1);
        tick();
    endtask

    task automatic wait_samples(input int n, input int budget);
        int seen;
        int i;
        seen = 0;
        i = 0;
        while (seen < n && i < budget) begin
            @(negedge clk);
            i++;
            if (sample_req) seen++;
        end
        check("samples_seen", seen, n);
    endtask

    task automatic end_of_scan(input int want_samples, input bit want_tmo);
        check("sample_count", n_samples, want_samples);
        check("done_count", n_done, 1);
        check("points_drained", exp_q.size(), 0);
        check("park_drained", done_h_q.size(), 0);
        check("busy_after_done", busy, 0);
        check("timeout_after_done", timeout, want_tmo);
    endtask

    // ADC model: answers each SAMPLE_REQ after resp_delay cycles (0 = never).
    initial begin
        forever begin
            @(negedge clk);
            if (sample_req && !rst) begin
                int d;
                d = resp_delay[resp_idx % 9];
                resp_idx++;
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1 adc_resp = 1'b1;
                    @(posedge clk);
                    #1 adc_resp = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT samples, closes a capture window, or finishes.
    pt_t         cur;
    bit          cur_valid = 1'b0;
    int          cap_len = 0;
    bit          prev_cap = 1'b0;
    bit          prev_busy = 1'b0;
    logic [31:0] prev_h, prev_v;
    int          since_chg = 0;

    always @(negedge clk) begin
        if (rst) begin
            cur_valid = 1'b0;
            cap_len   = 0;
            prev_cap  = 1'b0;
            prev_busy = 1'b0;
            since_chg = 0;
        end else begin
            if (pw_h != prev_h || pw_v != prev_v) since_chg = 0;
            else since_chg++;
            if (sample_req) begin
                n_samples++;
                if (exp_q.size() == 0) begin
                    check("sample_extra", exp_q.size(), 1);
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("pos_h", pw_h, cur.h);
                    check("pos_v", pw_v, cur.v);
                    check("capture_at_req", capture_en, 0);
                end
            end
            if (capture_en) begin
                cap_len++;
            end else if (prev_cap) begin
                check("window_owner", cur_valid, 1);
                if (cur_valid) begin
                    check("window_len", cap_len, cur.win);
                    check("timeout_flag", timeout, cur.tmo);
                end
                cur_valid = 1'b0;
                cap_len   = 0;
            end
            if (done) begin
                n_done++;
                check("busy_falls_with_done", {prev_busy, busy}, 2'b10);
                if (done_h_q.size() == 0) begin
                    check("done_extra", done_h_q.size(), 1);
                end else begin
                    check("park_h", pw_h, done_h_q.pop_front());
                    check("park_v", pw_v, done_v_q.pop_front());
                    check("park_settle", since_chg, SCYC);
                end
            end
            prev_cap  = capture_en;
            prev_busy = busy;
        end
        prev_h = pw_h;
        prev_v = pw_v;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        // Reset with START held: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_h", pw_h, 500);
        check("rst_v", pw_v, 500);
        check("rst_sample_req", sample_req, 0);
        check("rst_capture", capture_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_beats_start", busy, 0);

        // Clean full scan, then park on 600/700.
        for (int k = 0; k < 9; k++) begin
            resp_delay[k] = 2;
            win_v[k]      = 2;
            tmo_v[k]      = 1'b0;
        end
        push_scan(9, 1'b1);
        n_samples = 0;
        n_done    = 0;
        resp_idx  = 0;
        tick();
        pulse_start();
        @(negedge clk);
        check("busy_after_start", busy, 1);
        wait_done(1000);
        end_of_scan(9, 1'b0);

        // Point 3 never answers; point 6 answers one cycle too late.
        resp_delay = '{2, 2, 0, 2, 2, 9, 2, 2, 2};
        win_v      = '{2, 2, 8, 2, 2, 8, 2, 2, 2};
        tmo_v      = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
        push_scan(9, 1'b1);
        n_samples = 0;
        n_done    = 0;
        resp_idx  = 0;
        pulse_start();
        wait_done(1000);
        end_of_scan(9, 1'b1);
        repeat (3) tick();
        @(negedge clk);
        check("timeout_sticky_idle", timeout, 1);

        // Next START clears TIMEOUT; stray START and ADC_VALID mid-scan are ignored.
        for (int k = 0; k < 9; k++) begin
            resp_delay[k] = 2;
            win_v[k]      = 2;
            tmo_v[k]      = 1'b0;
        end
        push_scan(9, 1'b1);
        n_samples = 0;
        n_done    = 0;
        resp_idx  = 0;
        tick();
        pulse_start();
        @(negedge clk);
        check("timeout_cleared", timeout, 0);
        wait_samples(2, 200);
        repeat (6) @(posedge clk);
        #1 stray_valid = 1'b1;
        @(posedge clk);
        #1 stray_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("stray_capture", capture_en, 0);
        wait_done(1000);
        end_of_scan(9, 1'b0);

        // Reset during SETTLE of point 5 aborts without DONE.
        push_scan(4, 1'b0);
        n_samples = 0;
        n_done    = 0;
        resp_idx  = 0;
        tick();
        pulse_start();
        wait_samples(4, 200);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_h", pw_h, 500);
        check("abort_v", pw_v, 500);
        check("abort_busy", busy, 0);
        check("abort_capture", capture_en, 0);
        check("abort_sample_req", sample_req, 0);
        repeat (30) @(negedge clk);
        check("abort_no_done", n_done, 0);
        check("abort_samples", n_samples, 4);
        check("abort_points_drained", exp_q.size(), 0);

        // Restart from the origin; point 4 answers on the last window cycle.
        resp_delay = '{2, 2, 2, 8, 2, 2, 2, 2, 2};
        win_v      = '{2, 2, 2, 8, 2, 2, 2, 2, 2};
        for (int k = 0; k < 9; k++) tmo_v[k] = 1'b0;
        push_scan(9, 1'b1);
        n_samples = 0;
        n_done    = 0;
        resp_idx  = 0;
        tick();
        pulse_start();
        wait_done(1000);
        end_of_scan(9, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
